// File: rtl/ife_block_assembler.sv
// Packs a serial instruction stream into fixed-size, ID-tagged, NOP-padded blocks.
// A fill buffer plus an output register let the next block fill while the current one is back-pressured.
module ife_block_assembler #(
    parameter int                     BLOCK_ID_WIDTH = 8,
    parameter int                     INSTR_WIDTH    = 32,
    parameter int                     BLOCK_SIZE     = 4,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR      = 32'h00000013
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [INSTR_WIDTH-1:0]            instr_in,
    input  logic                              instr_valid,
    input  logic                              instr_last,
    output logic                              instr_ready,
    input  logic                              flush,
    output logic [BLOCK_ID_WIDTH-1:0]         block_id_out,
    output logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_data_out,
    output logic [$clog2(BLOCK_SIZE+1)-1:0]   block_len_out,
    output logic                              block_valid_out,
    input  logic                              block_ready_in
);

    localparam int CNT_WIDTH = $clog2(BLOCK_SIZE);
    localparam int LEN_WIDTH = $clog2(BLOCK_SIZE+1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                          state_reg, state_next;
    logic [CNT_WIDTH-1:0]            cnt_reg;
    logic [LEN_WIDTH-1:0]            hold_len_reg;
    logic [BLOCK_ID_WIDTH-1:0]       next_id_reg;
    logic [INSTR_WIDTH-1:0]          buf_reg [BLOCK_SIZE];
    logic [INSTR_WIDTH-1:0]          fill_view [BLOCK_SIZE];
    logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_next;

    logic                            out_valid_reg;
    logic [BLOCK_ID_WIDTH-1:0]       out_id_reg;
    logic [LEN_WIDTH-1:0]            out_len_reg;
    logic [BLOCK_SIZE*INSTR_WIDTH-1:0] out_data_reg;

    logic out_free;
    logic last_slot;
    logic accept;
    logic close;
    logic emit_live;
    logic emit_held;
    logic park;
    logic emit;
    logic [LEN_WIDTH-1:0] live_len;

    assign out_free  = !out_valid_reg || block_ready_in;
    assign last_slot = (cnt_reg == CNT_WIDTH'(BLOCK_SIZE-1));
    assign live_len  = LEN_WIDTH'(cnt_reg) + LEN_WIDTH'(1);
    assign emit      = emit_live || emit_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        instr_ready = 1'b0;
        accept      = 1'b0;
        close       = 1'b0;
        emit_live   = 1'b0;
        emit_held   = 1'b0;
        park        = 1'b0;
        case (state_reg)
            FILL: begin
                instr_ready = !flush;
                accept      = instr_valid && !flush;
                close       = accept && (last_slot || instr_last);
                if (close) begin
                    if (out_free) begin
                        emit_live = 1'b1;
                    end else begin
                        park       = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!flush && out_free) begin
                    emit_held  = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
        if (flush) begin
            state_next = FILL;
        end
    end

    // Slots above cnt are always NOP in the buffer (cleared on every emit/flush),
    // so the buffer with the live instruction overlaid is already the padded block.
    generate
        for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_slot
            assign fill_view[gi] = (accept && cnt_reg == CNT_WIDTH'(gi)) ? instr_in : buf_reg[gi];
            assign block_next[gi*INSTR_WIDTH +: INSTR_WIDTH] = fill_view[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    buf_reg[gi] <= NOP_INSTR;
                end else if (flush || emit) begin
                    buf_reg[gi] <= NOP_INSTR;
                end else if (accept && cnt_reg == CNT_WIDTH'(gi)) begin
                    buf_reg[gi] <= instr_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            hold_len_reg <= '0;
        end else if (flush || emit) begin
            cnt_reg <= '0;
        end else if (park) begin
            hold_len_reg <= live_len;
        end else if (accept) begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
    end

    // Flush drops the presented block; the ID counter only advances on emits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_id_reg    <= '0;
            out_len_reg   <= '0;
            out_data_reg  <= {BLOCK_SIZE{NOP_INSTR}};
            next_id_reg   <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (emit) begin
            out_valid_reg <= 1'b1;
            out_id_reg    <= next_id_reg;
            out_len_reg   <= emit_held ? hold_len_reg : live_len;
            out_data_reg  <= block_next;
            next_id_reg   <= next_id_reg + BLOCK_ID_WIDTH'(1);
        end else if (out_valid_reg && block_ready_in) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign block_valid_out = out_valid_reg;
    assign block_id_out    = out_id_reg;
    assign block_len_out   = out_len_reg;
    assign block_data_out  = out_data_reg;

endmodule
